gshare: RTL and testbench
=========================

# gshare

Global-history direction predictor for the fetch stage, downstream of the branch target buffer. Each cycle it combines the fetch PC with a speculative global history register (GHR) to index a table of 2-bit saturating counters. It qualifies the BTB hit into a taken/not-taken prediction. Resolved branches from EX train the table and, on a misprediction, restore the GHR from the snapshot carried down the pipeline.

## Interface
- `GHR_BITS`, default 10: history length and PHT index width; PHT holds 2^GHR_BITS entries; index PC bits are `pc_r[GHR_BITS+1:2]`.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `pc_r` in 32: fetch PC, the same value presented to the BTB.
- `btb_hit` in 1: BTB hit for `pc_r` in the same cycle.
- `rd_en` in 1: fetch accepts this cycle's prediction; enables the speculative GHR shift.
- `pred_taken` out 1: predicted direction, `btb_hit && ctr[pred_index][1]`.
- `pred_index` out GHR_BITS: `pc_r[GHR_BITS+1:2] ^ ghr`; carried to EX.
- `pred_ghr` out GHR_BITS: current GHR before this cycle's shift; carried to EX as the recovery snapshot.
- `upd_en` in 1: one branch resolved this cycle.
- `upd_index` in GHR_BITS: `pred_index` carried with the branch.
- `upd_taken` in 1: actual outcome.
- `upd_mispred` in 1: direction or target was mispredicted.
- `upd_ghr` in GHR_BITS: `pred_ghr` carried with the branch.
- `br_cnt` out 32: resolved-branch count.
- `mis_cnt` out 32: misprediction count.

## Operation
- PHT: 2^GHR_BITS 2-bit counters.
  - Values: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
  - Reset value 01 for every entry; the reset loop runs in the single `resetn`-low cycle.
- Training on `upd_en`:
  - `ctr[upd_index]` increments when `upd_taken` is 1 and decrements otherwise.
  - Counters saturate at 11 and 00; no wrap.
- Read bypass: when `upd_en` is 1 and `upd_index == pred_index`, `pred_taken` uses the post-update counter value, not the stored one.
- GHR, priority order:
  1. `!resetn`: ghr <= 0.
  2. `upd_en && upd_mispred`: ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}. Recovery wins; any same-cycle `rd_en` shift is discarded because that fetch is on the wrong path.
  3. `rd_en && btb_hit`: ghr <= {ghr[GHR_BITS-2:0], pred_taken}.
  4. Otherwise ghr holds.
- BTB misses never shift history at fetch.
  - The pipeline asserts `upd_mispred` for a BTB-missed branch that resolves taken, which shifts it in via recovery.
  - A BTB-missed branch that resolves not-taken leaves history unchanged.
- Perf counters:
  - `br_cnt` increments on `upd_en`; `mis_cnt` increments on `upd_en && upd_mispred`.
  - Both are 32-bit and wrap at 2^32-1 to 0.
  - Both reset to 0.
- Reset outputs (while `resetn` is low and the cycle after it):
  - ghr = 0, so `pred_ghr` = 0 and `pred_index` = `pc_r[GHR_BITS+1:2]`.
  - `pred_taken` is forced to 0 while `resetn` is low.
  - `br_cnt` = `mis_cnt` = 0.
- `upd_*` inputs are ignored while `resetn` is low.

## Timing
- Prediction path is combinational from `pc_r`, `btb_hit` and the GHR, in the same cycle as the BTB lookup; zero latency.
- PHT write lands at the rising edge. The same-cycle read sees it through the bypass; the following cycle reads it from storage.
- GHR update is visible on `pred_ghr` and `pred_index` in the cycle after the triggering edge.
- One update per cycle maximum.
- Training and the speculative shift are independent when `upd_mispred` is 0; both take effect at the same edge.
- Reset taken mid-operation discards all history and training. The first post-reset cycle behaves exactly as after power-on reset.

## Test plan
- Reset, then `pc_r`=0x00400000, `btb_hit`=1 -> `pred_index`=0x000, `pred_ghr`=0x000, `pred_taken`=0; `br_cnt`=`mis_cnt`=0.
- Two taken updates at `upd_index`=0x005; read `pc_r`=0x00400014 (GHR 0):
  - During the first update cycle, the bypass gives counter 10 -> `pred_taken`=1.
  - After both updates the counter is 11 -> `pred_taken`=1.
  - With `btb_hit`=0 -> `pred_taken`=0.
- Saturation on entry 0x005:
  - Three more taken updates keep it at 11.
  - One not-taken update gives 10 -> `pred_taken`=1.
  - A second not-taken update gives 01 -> `pred_taken`=0.
  - Five further not-taken updates hold it at 00.
- Speculative shift: GHR 0x000, counter at 0x005 = 11, `rd_en`=1, `btb_hit`=1, `pc_r`=0x00400014:
  - Next cycle `pred_ghr`=0x001 and `pred_index`=0x004 for the same PC.
  - `rd_en`=1 with `btb_hit`=0 leaves the GHR unchanged.
- Recovery priority: GHR 0x3FF; same cycle `rd_en`=1, `btb_hit`=1, `upd_en`=1, `upd_mispred`=1, `upd_ghr`=0x155, `upd_taken`=0:
  - Next cycle `pred_ghr`=0x2AA.
  - `br_cnt` and `mis_cnt` each increment by 1.
- Mid-run reset after the above: one cycle `resetn`=0 -> GHR 0, counters 0, every PHT entry 01; `pc_r`=0x00400014 with `btb_hit`=1 -> `pred_taken`=0.

Source files
------------

// File: rtl/gshare_if.sv
// gshare_if: fetch/EX-side bundle for the gshare direction predictor.
//   Fetch lookup : pc_r, btb_hit, rd_en  -> pred_taken, pred_index, pred_ghr
//   EX training  : upd_en, upd_index, upd_taken, upd_mispred, upd_ghr
//   Perf counters: br_cnt, mis_cnt
// master = pipeline side (drives lookups/updates), slave = predictor.
interface gshare_if #(
  parameter int unsigned GHR_BITS = 10
);
  logic [31:0]         pc_r;
  logic                btb_hit;
  logic                rd_en;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_index;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                upd_en;
  logic [GHR_BITS-1:0] upd_index;
  logic                upd_taken;
  logic                upd_mispred;
  logic [GHR_BITS-1:0] upd_ghr;
  logic [31:0]         br_cnt;
  logic [31:0]         mis_cnt;

  modport master (
    output pc_r, btb_hit, rd_en,
    output upd_en, upd_index, upd_taken, upd_mispred, upd_ghr,
    input  pred_taken, pred_index, pred_ghr, br_cnt, mis_cnt
  );

  modport slave (
    input  pc_r, btb_hit, rd_en,
    input  upd_en, upd_index, upd_taken, upd_mispred, upd_ghr,
    output pred_taken, pred_index, pred_ghr, br_cnt, mis_cnt
  );
endinterface

// File: rtl/gshare.sv
// gshare: global-history branch direction predictor.
//   clk    : single clock, all state on the rising edge
//   resetn : synchronous active-low reset (GHR=0, PHT entries=01, counters=0)
//   bp     : gshare_if.slave bundle
//     pred_* is combinational from pc_r, btb_hit and the GHR (zero latency).
//     upd_* trains the 2-bit counter table; upd_mispred restores the GHR
//     from the carried snapshot, overriding any same-cycle speculative shift.
module gshare #(
  parameter int unsigned GHR_BITS = 10
) (
  input logic     clk,
  input logic     resetn,
  gshare_if.slave bp
);
  localparam int unsigned DEPTH = 1 << GHR_BITS;

  logic [1:0]          r_pht [DEPTH];
  logic [GHR_BITS-1:0] r_ghr;
  logic [31:0]         r_br_cnt;
  logic [31:0]         r_mis_cnt;

  logic [GHR_BITS-1:0] w_pc_idx;
  logic [GHR_BITS-1:0] w_pred_index;
  logic [1:0]          w_upd_old;
  logic [1:0]          w_upd_new;
  logic [1:0]          w_rd_ctr;
  logic                w_pred_taken;
  logic                w_unused_pc;

  assign w_pc_idx     = bp.pc_r[GHR_BITS+1:2];
  assign w_pred_index = w_pc_idx ^ r_ghr;
  assign w_unused_pc  = ^{bp.pc_r[31:GHR_BITS+2], bp.pc_r[1:0]};

  always_comb begin
    w_upd_old = r_pht[bp.upd_index];
    w_upd_new = w_upd_old;
    if (bp.upd_taken) begin
      if (w_upd_old != 2'b11) w_upd_new = w_upd_old + 2'd1;
    end else begin
      if (w_upd_old != 2'b00) w_upd_new = w_upd_old - 2'd1;
    end
    // Same-cycle write to the entry being read: forward the post-update value.
    w_rd_ctr = r_pht[w_pred_index];
    if (bp.upd_en && (bp.upd_index == w_pred_index)) w_rd_ctr = w_upd_new;
  end

  assign w_pred_taken = resetn & bp.btb_hit & w_rd_ctr[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pht[i[GHR_BITS-1:0]] <= 2'b01;
      r_ghr     <= '0;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (bp.upd_en) begin
        r_pht[bp.upd_index] <= w_upd_new;
        r_br_cnt            <= r_br_cnt + 32'd1;
        if (bp.upd_mispred) r_mis_cnt <= r_mis_cnt + 32'd1;
      end
      // Recovery outranks the speculative shift: that fetch is on the wrong path.
      if (bp.upd_en && bp.upd_mispred)
        r_ghr <= {bp.upd_ghr[GHR_BITS-2:0], bp.upd_taken};
      else if (bp.rd_en && bp.btb_hit)
        r_ghr <= {r_ghr[GHR_BITS-2:0], w_pred_taken};
    end
  end

  assign bp.pred_taken = w_pred_taken;
  assign bp.pred_index = w_pred_index;
  assign bp.pred_ghr   = r_ghr;
  assign bp.br_cnt     = r_br_cnt;
  assign bp.mis_cnt    = r_mis_cnt;
endmodule

// File: tb/tb_gshare.sv
// tb_gshare: directed self-checking bench for gshare (GHR_BITS = 10).
module tb_gshare;
  logic clk;
  logic resetn;
  int   total;
  int   bad;

  gshare_if #(.GHR_BITS(10)) bus ();

  gshare #(.GHR_BITS(10)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bp     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic upd(input logic [9:0] idx, input logic taken, input int unsigned n);
    bus.upd_en    = 1'b1;
    bus.upd_index = idx;
    bus.upd_taken = taken;
    for (int unsigned k = 0; k < n; k++) tick();
    bus.upd_en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn          = 1'b0;
    bus.pc_r        = 32'h0040_0000;
    bus.btb_hit     = 1'b1;
    bus.rd_en       = 1'b0;
    bus.upd_en      = 1'b0;
    bus.upd_index   = '0;
    bus.upd_taken   = 1'b0;
    bus.upd_mispred = 1'b0;
    bus.upd_ghr     = '0;

    // Power-on reset
    tick();
    tick();
    #1;
    check("rst_taken_low", {31'd0, bus.pred_taken}, 32'd0);
    check("rst_ghr_low",   {22'd0, bus.pred_ghr},   32'd0);
    resetn = 1'b1;
    #1;
    check("rst_index", {22'd0, bus.pred_index}, 32'h000);
    check("rst_ghr",   {22'd0, bus.pred_ghr},   32'h000);
    check("rst_taken", {31'd0, bus.pred_taken}, 32'd0);
    check("rst_br",    bus.br_cnt,  32'd0);
    check("rst_mis",   bus.mis_cnt, 32'd0);

    // Training with bypass on entry 0x005
    bus.pc_r      = 32'h0040_0014;
    bus.upd_en    = 1'b1;
    bus.upd_index = 10'h005;
    bus.upd_taken = 1'b1;
    #1;
    check("bypass_01_to_10", {31'd0, bus.pred_taken}, 32'd1);
    check("pc_index",        {22'd0, bus.pred_index}, 32'h005);
    tick();
    #1;
    check("bypass_10_to_11", {31'd0, bus.pred_taken}, 32'd1);
    tick();
    bus.upd_en = 1'b0;
    #1;
    check("stored_11", {31'd0, bus.pred_taken}, 32'd1);
    bus.btb_hit = 1'b0;
    #1;
    check("btb_miss_not_taken", {31'd0, bus.pred_taken}, 32'd0);
    check("br_after_2", bus.br_cnt, 32'd2);
    bus.btb_hit = 1'b1;

    // Saturation
    upd(10'h005, 1'b1, 3);
    #1;
    check("sat_high_11", {31'd0, bus.pred_taken}, 32'd1);
    upd(10'h005, 1'b0, 1);
    #1;
    check("dec_to_10", {31'd0, bus.pred_taken}, 32'd1);
    upd(10'h005, 1'b0, 1);
    #1;
    check("dec_to_01", {31'd0, bus.pred_taken}, 32'd0);
    upd(10'h005, 1'b0, 5);
    // From 00 one taken step gives 01 (not taken) through the bypass
    bus.upd_en    = 1'b1;
    bus.upd_index = 10'h005;
    bus.upd_taken = 1'b1;
    #1;
    check("sat_low_00", {31'd0, bus.pred_taken}, 32'd0);
    tick();
    upd(10'h005, 1'b1, 2);
    #1;
    check("back_to_11", {31'd0, bus.pred_taken}, 32'd1);
    check("br_after_15", bus.br_cnt,  32'd15);
    check("mis_zero",    bus.mis_cnt, 32'd0);

    // Speculative shift
    bus.rd_en = 1'b1;
    #1;
    check("shift_pre_ghr", {22'd0, bus.pred_ghr}, 32'h000);
    tick();
    bus.rd_en = 1'b0;
    #1;
    check("shift_ghr_1",   {22'd0, bus.pred_ghr},   32'h001);
    check("shift_index_4", {22'd0, bus.pred_index}, 32'h004);
    check("entry4_weak_nt", {31'd0, bus.pred_taken}, 32'd0);
    bus.rd_en   = 1'b1;
    bus.btb_hit = 1'b0;
    tick();
    #1;
    check("miss_no_shift", {22'd0, bus.pred_ghr}, 32'h001);
    bus.btb_hit = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    #1;
    check("shift_in_zero", {22'd0, bus.pred_ghr},   32'h002);
    check("shift_index_7", {22'd0, bus.pred_index}, 32'h007);

    // Recovery to 0x3FF
    bus.upd_en      = 1'b1;
    bus.upd_mispred = 1'b1;
    bus.upd_index   = 10'h3FF;
    bus.upd_taken   = 1'b1;
    bus.upd_ghr     = 10'h1FF;
    tick();
    bus.upd_en      = 1'b0;
    bus.upd_mispred = 1'b0;
    #1;
    check("recover_3ff",  {22'd0, bus.pred_ghr},   32'h3FF);
    check("index_3fa",    {22'd0, bus.pred_index}, 32'h3FA);

    // Recovery outranks same-cycle speculative shift
    bus.rd_en       = 1'b1;
    bus.btb_hit     = 1'b1;
    bus.upd_en      = 1'b1;
    bus.upd_mispred = 1'b1;
    bus.upd_index   = 10'h010;
    bus.upd_taken   = 1'b0;
    bus.upd_ghr     = 10'h155;
    tick();
    bus.rd_en       = 1'b0;
    bus.upd_en      = 1'b0;
    bus.upd_mispred = 1'b0;
    #1;
    check("recover_priority", {22'd0, bus.pred_ghr}, 32'h2AA);
    check("br_after_17",  bus.br_cnt,  32'd17);
    check("mis_after_2",  bus.mis_cnt, 32'd2);

    // Mid-run reset, with update inputs active that must be ignored
    resetn          = 1'b0;
    bus.pc_r        = 32'h0040_0014;
    bus.upd_en      = 1'b1;
    bus.upd_mispred = 1'b1;
    bus.upd_index   = 10'h005;
    bus.upd_taken   = 1'b1;
    bus.upd_ghr     = 10'h0AA;
    #1;
    check("midrst_taken_low", {31'd0, bus.pred_taken}, 32'd0);
    tick();
    resetn          = 1'b1;
    bus.upd_en      = 1'b0;
    bus.upd_mispred = 1'b0;
    #1;
    check("midrst_ghr",   {22'd0, bus.pred_ghr},   32'h000);
    check("midrst_index", {22'd0, bus.pred_index}, 32'h005);
    check("midrst_pht5",  {31'd0, bus.pred_taken}, 32'd0);
    check("midrst_br",    bus.br_cnt,  32'd0);
    check("midrst_mis",   bus.mis_cnt, 32'd0);
    bus.pc_r = 32'h0040_0FFC;
    #1;
    check("midrst_index_3ff", {22'd0, bus.pred_index}, 32'h3FF);
    check("midrst_pht3ff",    {31'd0, bus.pred_taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
